image_circle_fetch: RTL and testbench
=====================================

IMAGE_CIRCLE_FETCH -- requirements
Module: image_circle_fetch

Interface
REQ-001 SHALL have parameter PIXEL_DEPTH, default 8: pixel width in bits.
REQ-002 SHALL have parameter X_MAX, default 7: image width in pixels; legal range is X_MAX >= 4.
REQ-003 SHALL have parameter Y_MAX, default 7: image height in pixels; legal range is Y_MAX >= 4.
REQ-004 SHALL have port ramclk, input, 1 bit: the single clock; all state is on the rising edge.
REQ-005 SHALL have port n_rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: fetch request, sampled only in IDLE.
REQ-007 SHALL have port cx, input, signed $clog2(X_MAX)+1 bits: centre x, legal range 0..X_MAX-1.
REQ-008 SHALL have port cy, input, signed $clog2(Y_MAX)+1 bits: centre y, legal range 0..Y_MAX-1.
REQ-009 SHALL have port x_addr, output, signed $clog2(X_MAX)+1 bits: image-RAM x address.
REQ-010 SHALL have port y_addr, output, signed $clog2(Y_MAX)+1 bits: image-RAM y address.
REQ-011 SHALL have port ren, output, 1 bit: image-RAM read enable.
REQ-012 SHALL have port rdat, input, PIXEL_DEPTH bits: image-RAM read data, valid one cycle after ren; the RAM returns 0 for out-of-bounds addresses.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when a result is ready.
REQ-015 SHALL have port center_px, output, PIXEL_DEPTH bits: captured centre pixel.
REQ-016 SHALL have port ring_px, output, 16*PIXEL_DEPTH bits: ring pixel i in bits [i*PIXEL_DEPTH +: PIXEL_DEPTH].

Function
REQ-017 SHALL use FSM states IDLE, ISSUE, DRAIN and DONE.
REQ-018 SHALL move IDLE->ISSUE at the edge where start=1, and latch cx and cy at that edge (edge E0).
REQ-019 SHALL hold ISSUE for exactly 17 cycles; read index k=0..16 is issued in the cycle after edge Ek with ren=1.
REQ-020 SHALL issue index 0 as the centre (dx,dy)=(0,0).
REQ-021 SHALL issue ring indices 1..16 as radius-3 Bresenham offsets, clockwise from the top: (0,-3)(1,-3)(2,-2)(3,-1)(3,0)(3,1)(2,2)(1,3)(0,3)(-1,3)(-2,2)(-3,1)(-3,0)(-3,-1)(-2,-2)(-1,-3).
REQ-022 SHALL drive x_addr=cx+dx and y_addr=cy+dy in signed port width, with no clamping; off-image and negative results are passed through so the RAM returns 0 for them.
REQ-023 SHALL capture rdat for read index k at edge Ek+2, into center_px for k=0 and into ring slot k-1 otherwise.
REQ-024 SHALL pass through ISSUE(17 cycles)->DRAIN(1 cycle)->DONE(1 cycle)->IDLE.
REQ-025 SHALL assert done during the DONE cycle, i.e. for the one cycle after edge E18, with all outputs final at that point.
REQ-026 SHALL drive ren=0, x_addr=0 and y_addr=0 whenever the FSM is outside ISSUE.
REQ-027 SHALL ignore start while busy=1.
REQ-028 SHALL accept a start asserted during the DONE cycle only on the following IDLE cycle; back-to-back throughput is 20 cycles per fetch.
REQ-029 SHALL hold center_px and ring_px from done until the next capture overwrites them.
REQ-030 SHALL never drive the RAM write enable.

Reset
REQ-031 SHALL, on n_rst=0 at any time including mid-fetch, immediately force IDLE, busy=0, done=0, ren=0, all addresses to 0, center_px=0, ring_px=0 and all masks to 0.
REQ-032 SHALL discard any partial capture interrupted by reset; the first edge with n_rst=1 is in IDLE.

Configuration
REQ-033 SHALL, with FAST_COMPARE_EN defined, add input thresh (PIXEL_DEPTH bits), output bright_mask (16 bits) and output dark_mask (16 bits).
REQ-034 SHALL, under FAST_COMPARE_EN, set bright_mask[i]=(ring_i > center+thresh) and dark_mask[i]=(ring_i < center-thresh), computed in PIXEL_DEPTH+2 signed bits with no wrap.
REQ-035 SHALL, under FAST_COMPARE_EN, register both masks so they update on the same edge as done.
REQ-036 SHALL, without FAST_COMPARE_EN, omit those ports and the compare logic, leaving timing otherwise identical.

Structure
REQ-037 SHALL place the FSM state enum, RING_N=16, READS_N=17 and the signed dx/dy offset tables in shared package fast_pkg.
REQ-038 SHALL implement the comparison as sub-module fast_px_compare (one ring pixel versus centre and thresh, giving bright and dark bits), instantiated 16 times only under FAST_COMPARE_EN.

Verification
REQ-039 SHALL cover: 7x7 image, pixel = 10*y+x, start with (cx,cy)=(3,3) -> center_px=33, ring slot0=03, slot4=36, slot8=63, slot12=30, done at E18.
REQ-040 SHALL cover: (cx,cy)=(0,0) on the same image -> slots for negative coordinates read 0 (slot0=0, slot12=0), slot4=03, slot8=30.
REQ-041 SHALL cover: start held high for 40 cycles -> exactly two done pulses, 20 cycles apart, with busy never dropping to 0 mid-fetch.
REQ-042 SHALL cover: n_rst pulsed low at E9 -> ren=0, busy=0 and all outputs 0 immediately, no done pulse, and a fresh start after release gives correct data.
REQ-043 SHALL cover, with FAST_COMPARE_EN: flat image of 100 except ring slots 0-8 = 150, thresh=20 -> bright_mask=16'h01FF and dark_mask=0.
REQ-044 SHALL cover, with FAST_COMPARE_EN: centre=250, thresh=10, ring=255 -> bright_mask=0 (no wrap); centre=5, ring=0 -> dark_mask=0.

Source files
------------

// File: rtl/fast_pkg.sv
// Shared types and constants for the circle fetch: FSM states, read counts and
// the radius-3 Bresenham ring offsets, clockwise from the top.
package fast_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} fetch_state_e;

    localparam int RING_N  = 16;
    localparam int READS_N = 17;

    localparam logic signed [2:0] RING_DX [RING_N] = '{
        3'sd0,  3'sd1,  3'sd2,  3'sd3,  3'sd3,  3'sd3,  3'sd2,  3'sd1,
        3'sd0, -3'sd1, -3'sd2, -3'sd3, -3'sd3, -3'sd3, -3'sd2, -3'sd1
    };

    localparam logic signed [2:0] RING_DY [RING_N] = '{
       -3'sd3, -3'sd3, -3'sd2, -3'sd1,  3'sd0,  3'sd1,  3'sd2,  3'sd3,
        3'sd3,  3'sd3,  3'sd2,  3'sd1,  3'sd0, -3'sd1, -3'sd2, -3'sd3
    };

endpackage

// File: rtl/fast_px_compare.sv
// One ring pixel against centre +/- threshold; two extra bits keep the sums
// from wrapping at either end of the pixel range.
module fast_px_compare #(
    parameter int PIXEL_DEPTH = 8
) (
    input  logic [PIXEL_DEPTH-1:0] ring,
    input  logic [PIXEL_DEPTH-1:0] center,
    input  logic [PIXEL_DEPTH-1:0] thresh,
    output logic                   bright,
    output logic                   dark
);

    logic signed [PIXEL_DEPTH+1:0] ring_s, center_s, thresh_s;

    assign ring_s   = $signed({2'b00, ring});
    assign center_s = $signed({2'b00, center});
    assign thresh_s = $signed({2'b00, thresh});

    assign bright = ring_s > (center_s + thresh_s);
    assign dark   = ring_s < (center_s - thresh_s);

endmodule

// File: rtl/image_circle_fetch.sv
// Fetches the centre pixel and 16 radius-3 ring pixels from an image RAM.
// Optional build macro FAST_COMPARE_EN adds registered bright/dark masks.
module image_circle_fetch
    import fast_pkg::*;
#(
    parameter int PIXEL_DEPTH = 8,
    parameter int X_MAX       = 7,
    parameter int Y_MAX       = 7,
    localparam int XW         = $clog2(X_MAX) + 1,
    localparam int YW         = $clog2(Y_MAX) + 1
) (
    input  logic                          ramclk,
    input  logic                          n_rst,
    input  logic                          start,
    input  logic signed [XW-1:0]          cx,
    input  logic signed [YW-1:0]          cy,
    output logic signed [XW-1:0]          x_addr,
    output logic signed [YW-1:0]          y_addr,
    output logic                          ren,
    input  logic [PIXEL_DEPTH-1:0]        rdat,
    output logic                          busy,
    output logic                          done,
    output logic [PIXEL_DEPTH-1:0]        center_px,
    output logic [RING_N*PIXEL_DEPTH-1:0] ring_px
`ifdef FAST_COMPARE_EN
    ,
    input  logic [PIXEL_DEPTH-1:0]        thresh,
    output logic [RING_N-1:0]             bright_mask,
    output logic [RING_N-1:0]             dark_mask
`endif
);

    fetch_state_e state_q, state_d;
    logic [4:0]                    k_q;
    logic [3:0]                    ring_idx;
    logic signed [XW-1:0]          cx_q;
    logic signed [YW-1:0]          cy_q;
    logic signed [2:0]             dx, dy;
    logic                          pend_valid_q;
    logic [4:0]                    pend_idx_q;
    logic [PIXEL_DEPTH-1:0]        center_q, center_d;
    logic [RING_N*PIXEL_DEPTH-1:0] ring_q, ring_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ISSUE;
            ISSUE:   if (k_q == 5'(READS_N - 1)) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read 0 is the centre; read k>0 uses ring offset k-1.
    assign ring_idx = 4'(k_q - 5'd1);

    always_comb begin
        dx = '0;
        dy = '0;
        if (k_q != '0) begin
            dx = RING_DX[ring_idx];
            dy = RING_DY[ring_idx];
        end
    end

    always_comb begin
        ren    = 1'b0;
        x_addr = '0;
        y_addr = '0;
        if (state_q == ISSUE) begin
            ren    = 1'b1;
            x_addr = cx_q + XW'(dx);
            y_addr = cy_q + YW'(dy);
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    // Data for a read lands one cycle after ren, so capture from a one-deep pending slot.
    always_comb begin
        center_d = center_q;
        ring_d   = ring_q;
        if (pend_valid_q) begin
            if (pend_idx_q == '0) center_d = rdat;
            for (int i = 0; i < RING_N; i++) begin
                if (pend_idx_q == 5'(i + 1)) ring_d[i*PIXEL_DEPTH +: PIXEL_DEPTH] = rdat;
            end
        end
    end

    always_ff @(posedge ramclk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            k_q          <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            pend_valid_q <= 1'b0;
            pend_idx_q   <= '0;
            center_q     <= '0;
            ring_q       <= '0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= ren;
            pend_idx_q   <= k_q;
            center_q     <= center_d;
            ring_q       <= ring_d;
            if (state_q == IDLE && start) begin
                k_q  <= '0;
                cx_q <= cx;
                cy_q <= cy;
            end else if (state_q == ISSUE) begin
                k_q <= k_q + 5'd1;
            end
        end
    end

    assign center_px = center_q;
    assign ring_px   = ring_q;

`ifdef FAST_COMPARE_EN
    logic [RING_N-1:0] bright_d, dark_d, bright_q, dark_q;

    // Compare against the next-state captures so masks land with done.
    for (genvar g = 0; g < RING_N; g++) begin : g_cmp
        fast_px_compare #(
            .PIXEL_DEPTH(PIXEL_DEPTH)
        ) u_cmp (
            .ring  (ring_d[g*PIXEL_DEPTH +: PIXEL_DEPTH]),
            .center(center_d),
            .thresh(thresh),
            .bright(bright_d[g]),
            .dark  (dark_d[g])
        );
    end

    always_ff @(posedge ramclk or negedge n_rst) begin
        if (!n_rst) begin
            bright_q <= '0;
            dark_q   <= '0;
        end else if (state_q == DRAIN) begin
            bright_q <= bright_d;
            dark_q   <= dark_d;
        end
    end

    assign bright_mask = bright_q;
    assign dark_mask   = dark_q;
`endif

endmodule

// File: tb/tb_image_circle_fetch.sv
// Bench for image_circle_fetch on a 7x7 image; define FAST_COMPARE_EN to
// also cover the bright/dark masks.
module tb_image_circle_fetch;

    localparam int PD = 8;
    localparam int XW = $clog2(7) + 1;
    localparam int YW = $clog2(7) + 1;

    logic                   ramclk, n_rst, start, ren, busy, done;
    logic signed [XW-1:0]   cx, x_addr;
    logic signed [YW-1:0]   cy, y_addr;
    logic [PD-1:0]          rdat, center_px;
    logic [16*PD-1:0]       ring_px;
    logic [PD-1:0]          thresh;
    logic [15:0]            bright_mask, dark_mask;

    image_circle_fetch #(.PIXEL_DEPTH(PD), .X_MAX(7), .Y_MAX(7)) dut (
        .ramclk   (ramclk),
        .n_rst    (n_rst),
        .start    (start),
        .cx       (cx),
        .cy       (cy),
        .x_addr   (x_addr),
        .y_addr   (y_addr),
        .ren      (ren),
        .rdat     (rdat),
        .busy     (busy),
        .done     (done),
        .center_px(center_px),
        .ring_px  (ring_px)
`ifdef FAST_COMPARE_EN
        ,
        .thresh     (thresh),
        .bright_mask(bright_mask),
        .dark_mask  (dark_mask)
`endif
    );

`ifndef FAST_COMPARE_EN
    assign bright_mask = '0;
    assign dark_mask   = '0;
`endif

    int tb_dx [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
    int tb_dy [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

    logic [PD-1:0] img [7][7];
    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [PD-1:0]    center;
        logic [16*PD-1:0] ring;
        logic [15:0]      bright;
        logic [15:0]      dark;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    initial begin
        ramclk = 1'b0;
        forever #5 ramclk = ~ramclk;
    end

    function automatic logic [PD-1:0] pix(int x, int y);
        if (x < 0 || x >= 7 || y < 0 || y >= 7) return '0;
        return img[y][x];
    endfunction

    // Registered-read RAM model, zero outside the image.
    always @(posedge ramclk) begin
        if (ren) rdat <= pix(int'(x_addr), int'(y_addr));
        else     rdat <= '0;
    end

    function automatic void push_exp(int fx, int fy);
        exp_t e;
        int c, r;
        e = '0;
        e.center = pix(fx, fy);
        c = int'(e.center);
        for (int i = 0; i < 16; i++) begin
            e.ring[i*PD +: PD] = pix(fx + tb_dx[i], fy + tb_dy[i]);
            r = int'(e.ring[i*PD +: PD]);
`ifdef FAST_COMPARE_EN
            e.bright[i] = (r > c + int'(thresh));
            e.dark[i]   = (r < c - int'(thresh));
`endif
        end
        sb.push_back(e);
    endfunction

    function automatic void load_ramp();
        for (int y = 0; y < 7; y++)
            for (int x = 0; x < 7; x++) img[y][x] = PD'(10 * y + x);
    endfunction

    // Scoreboard: every done pops one expected result.
    always @(negedge ramclk) begin
        if (n_rst && done) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: got done=1 want no result pending");
            end else begin
                mon_e = sb.pop_front();
                if (center_px !== mon_e.center) begin
                    n_err++;
                    $display("FAIL sb_center: got %0d want %0d", center_px, mon_e.center);
                end
                for (int i = 0; i < 16; i++) begin
                    n_vec++;
                    if (ring_px[i*PD +: PD] !== mon_e.ring[i*PD +: PD]) begin
                        n_err++;
                        $display("FAIL sb_ring%0d: got %0d want %0d", i,
                                 ring_px[i*PD +: PD], mon_e.ring[i*PD +: PD]);
                    end
                end
`ifdef FAST_COMPARE_EN
                n_vec++;
                if (bright_mask !== mon_e.bright || dark_mask !== mon_e.dark) begin
                    n_err++;
                    $display("FAIL sb_masks: got %h/%h want %h/%h", bright_mask, dark_mask,
                             mon_e.bright, mon_e.dark);
                end
`endif
            end
        end
    end

    task automatic fetch(input int fx, input int fy);
        int c, ren_n;
        push_exp(fx, fy);
        cx = XW'(fx);
        cy = YW'(fy);
        start = 1'b1;
        @(posedge ramclk); #1;
        start = 1'b0;
        c = 0;
        ren_n = 0;
        n_vec++;
        if (ren !== 1'b1 || x_addr !== XW'(fx) || y_addr !== YW'(fy)) begin
            n_err++;
            $display("FAIL addr_center: got ren=%b %0d,%0d want 1 %0d,%0d", ren, x_addr, y_addr,
                     fx, fy);
        end
        while (!done && c < 30) begin
            if (ren) ren_n++;
            @(posedge ramclk); #1;
            c++;
            if (c == 1) begin
                n_vec++;
                if (x_addr !== XW'(fx) || y_addr !== YW'(fy - 3)) begin
                    n_err++;
                    $display("FAIL addr_ring0: got %0d,%0d want %0d,%0d", x_addr, y_addr,
                             fx, fy - 3);
                end
            end
        end
        n_vec++;
        if (c != 18) begin
            n_err++;
            $display("FAIL done_latency: got %0d cycles want 18", c);
        end
        n_vec++;
        if (ren_n != 17) begin
            n_err++;
            $display("FAIL ren_count: got %0d want 17", ren_n);
        end
        @(posedge ramclk); #1;
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0 || ren !== 1'b0 || x_addr !== '0 || y_addr !== '0) begin
            n_err++;
            $display("FAIL after_done: got done=%b busy=%b ren=%b addr=%0d,%0d want 0 0 0 0,0",
                     done, busy, ren, x_addr, y_addr);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        start = 1'b0;
        cx = '0;
        cy = '0;
        thresh = '0;
        #2;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || ren !== 1'b0 || center_px !== '0 ||
            ring_px !== '0 || x_addr !== '0 || y_addr !== '0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b done=%b ren=%b c=%0h want all 0",
                     busy, done, ren, center_px);
        end
        n_vec++;
        if (bright_mask !== '0 || dark_mask !== '0) begin
            n_err++;
            $display("FAIL reset_masks: got %h/%h want 0/0", bright_mask, dark_mask);
        end
        @(posedge ramclk); @(posedge ramclk); #1;
        n_rst = 1'b1;
    endtask

    task automatic test_center();
        load_ramp();
        fetch(3, 3);
        n_vec++;
        if (center_px !== 8'd33 || ring_px[0*PD +: PD] !== 8'd3 || ring_px[4*PD +: PD] !== 8'd36
            || ring_px[8*PD +: PD] !== 8'd63 || ring_px[12*PD +: PD] !== 8'd30) begin
            n_err++;
            $display("FAIL center_33: got c=%0d s0=%0d s4=%0d s8=%0d s12=%0d want 33 3 36 63 30",
                     center_px, ring_px[0 +: PD], ring_px[4*PD +: PD], ring_px[8*PD +: PD],
                     ring_px[12*PD +: PD]);
        end
    endtask

    task automatic test_corner();
        load_ramp();
        fetch(0, 0);
        n_vec++;
        if (center_px !== 8'd0 || ring_px[0*PD +: PD] !== 8'd0 || ring_px[4*PD +: PD] !== 8'd3
            || ring_px[8*PD +: PD] !== 8'd30 || ring_px[12*PD +: PD] !== 8'd0) begin
            n_err++;
            $display("FAIL corner_00: got c=%0d s0=%0d s4=%0d s8=%0d s12=%0d want 0 0 3 30 0",
                     center_px, ring_px[0 +: PD], ring_px[4*PD +: PD], ring_px[8*PD +: PD],
                     ring_px[12*PD +: PD]);
        end
    endtask

    task automatic test_back_to_back();
        int first, n_done, busy_gap;
        load_ramp();
        push_exp(2, 5);
        push_exp(2, 5);
        cx = XW'(2);
        cy = YW'(5);
        start = 1'b1;
        first = -1;
        n_done = 0;
        busy_gap = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge ramclk); #1;
            if (done) begin
                n_done++;
                if (first < 0) first = c;
                else begin
                    n_vec++;
                    if (c - first != 20) begin
                        n_err++;
                        $display("FAIL b2b_spacing: got %0d want 20", c - first);
                    end
                end
            end
            if (!busy && c != 19 && c != 39) busy_gap++;
        end
        start = 1'b0;
        n_vec++;
        if (n_done != 2 || first != 18) begin
            n_err++;
            $display("FAIL b2b_pulses: got %0d pulses first at %0d want 2 at 18", n_done, first);
        end
        n_vec++;
        if (busy_gap != 0) begin
            n_err++;
            $display("FAIL b2b_busy: got %0d idle cycles mid-fetch want 0", busy_gap);
        end
        repeat (3) @(posedge ramclk);
        #1;
    endtask

    task automatic test_reset_mid();
        int n_done;
        load_ramp();
        push_exp(4, 2);
        cx = XW'(4);
        cy = YW'(2);
        start = 1'b1;
        @(posedge ramclk); #1;
        start = 1'b0;
        repeat (9) @(posedge ramclk);
        #1;
        n_rst = 1'b0;
        #1;
        n_vec++;
        if (ren !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || center_px !== '0 ||
            ring_px !== '0 || x_addr !== '0 || y_addr !== '0) begin
            n_err++;
            $display("FAIL mid_reset: got ren=%b busy=%b done=%b c=%0d want all 0",
                     ren, busy, done, center_px);
        end
        sb.delete();
        @(posedge ramclk); @(posedge ramclk); #1;
        n_rst = 1'b1;
        n_done = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge ramclk); #1;
            if (done) n_done++;
        end
        n_vec++;
        if (n_done != 0) begin
            n_err++;
            $display("FAIL mid_reset_done: got %0d pulses want 0", n_done);
        end
        fetch(2, 4);
        n_vec++;
        if (center_px !== 8'd42) begin
            n_err++;
            $display("FAIL post_reset_center: got %0d want 42", center_px);
        end
    endtask

`ifdef FAST_COMPARE_EN
    task automatic test_fast_flat();
        for (int y = 0; y < 7; y++)
            for (int x = 0; x < 7; x++) img[y][x] = 8'd100;
        for (int i = 0; i < 9; i++) img[3 + tb_dy[i]][3 + tb_dx[i]] = 8'd150;
        thresh = 8'd20;
        fetch(3, 3);
        n_vec++;
        if (bright_mask !== 16'h01FF || dark_mask !== 16'h0000) begin
            n_err++;
            $display("FAIL fast_flat: got %h/%h want 01ff/0000", bright_mask, dark_mask);
        end
    endtask

    task automatic test_fast_nowrap();
        for (int y = 0; y < 7; y++)
            for (int x = 0; x < 7; x++) img[y][x] = 8'd255;
        img[3][3] = 8'd250;
        thresh = 8'd10;
        fetch(3, 3);
        n_vec++;
        if (bright_mask !== 16'h0000) begin
            n_err++;
            $display("FAIL fast_no_wrap_hi: got %h want 0000", bright_mask);
        end
        for (int y = 0; y < 7; y++)
            for (int x = 0; x < 7; x++) img[y][x] = 8'd0;
        img[3][3] = 8'd5;
        fetch(3, 3);
        n_vec++;
        if (dark_mask !== 16'h0000) begin
            n_err++;
            $display("FAIL fast_no_wrap_lo: got %h want 0000", dark_mask);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_center();
        test_corner();
        test_back_to_back();
        test_reset_mid();
`ifdef FAST_COMPARE_EN
        test_fast_flat();
        test_fast_nowrap();
`endif
        repeat (2) @(posedge ramclk);
        #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
